// File: rtl/cnt_modn.sv
// Parametrised synchronous modulo-N counter with up/down, clamped load,
// wrap/saturate mode, cascade enable/terminal count, wrap pulse and sticky overflow.
module cnt_modn #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 12,
  parameter int unsigned SATURATE = 0
) (
  input  logic             Clk,
  input  logic             MR,
  input  logic             CEP,
  input  logic             CET,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             OVF_CLR,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             C,
  output logic             OVF
);

  localparam int unsigned EXT_W = WIDTH + 1;
  localparam logic [WIDTH:0] TOP = EXT_W'(MODULUS - 1);

  generate
    if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
      $error("cnt_modn: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   d_ext;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] load_val;
  logic             at_term;
  logic             count_en;
  logic             ovf_set;

  // Next-count and load values; arithmetic kept one bit wider so MODULUS=2**WIDTH wraps cleanly
  always_comb begin
    q_ext    = {1'b0, Q};
    d_ext    = {1'b0, D};
    at_term  = UP ? (q_ext == TOP) : (q_ext == '0);
    count_en = CEP & CET & ~LD;
    ovf_set  = count_en & at_term;
    load_val = (d_ext > TOP) ? WIDTH'(TOP) : D;
    cnt_next = Q;
    if (at_term) begin
      if (SATURATE == 0) begin
        cnt_next = UP ? '0 : WIDTH'(TOP);
      end
    end else begin
      cnt_next = UP ? WIDTH'(q_ext + EXT_W'(1)) : WIDTH'(q_ext - EXT_W'(1));
    end
  end

  // Cascade output: no CEP dependency so it can feed the next stage's CET directly
  assign TC = CET & at_term;

  always_ff @(posedge Clk) begin
    if (MR) begin
      Q   <= '0;
      C   <= 1'b0;
      OVF <= 1'b0;
    end else begin
      if (LD) begin
        Q <= load_val;
      end else if (count_en) begin
        Q <= cnt_next;
      end
      C   <= ovf_set;
      OVF <= ovf_set | (OVF & ~OVF_CLR);
    end
  end

endmodule

// File: doc/cnt_modn.md
Name: cnt_modn

Overview:
- Parametrised synchronous modulo-N counter; the next generation of the team's fixed mod-12 counter.
- Adds:
  - generic width and modulus
  - up/down direction
  - parallel load with range clamping
  - wrap or saturate mode
  - cascadable enable/terminal count
  - registered wrap pulse and a sticky overflow flag
- Used as the building block for multi-digit counters, dividers and timebases in the counter lab designs.

Parameters:
- WIDTH, 4, counter register width in bits.
- MODULUS, 12, count range 0..MODULUS-1. Legal range: 2 <= MODULUS <= 2**WIDTH. Elaboration error otherwise.
- SATURATE, 0, 0 = wrap at terminal value, 1 = hold at terminal value.

Ports:
- Clk  input  1  rising-edge clock.
- MR  input  1  synchronous active-high reset.
- CEP  input  1  count enable (local).
- CET  input  1  count enable (cascade in); also gates TC.
- UP  input  1  1 = count up, 0 = count down.
- LD  input  1  synchronous parallel load.
- D  input  WIDTH  load value.
- OVF_CLR  input  1  synchronous clear of OVF.
- Q  output  WIDTH  current count.
- TC  output  1  terminal count, combinational (cascade out).
- C  output  1  registered wrap/terminal pulse.
- OVF  output  1  sticky overflow/underflow flag.

Behaviour:
- Clock and reset: one clock, Clk. Reset MR is synchronous and active-high. All state changes occur on the rising edge of Clk.
- Reset values: Q=0, C=0, OVF=0. TC is then purely combinational, i.e. CET & (UP==0) at Q=0.
- Terminal value T: MODULUS-1 when UP=1; 0 when UP=0.
- TC = CET & (Q==T). Zero latency, no dependency on CEP, so it can drive the next stage's CET.
- Priority per edge: MR > LD > count > hold.
- Load (LD=1):
  - Q <= D if D < MODULUS, else Q <= MODULUS-1 (clamp).
  - Load ignores CEP/CET.
  - C <= 0 on a load cycle.
  - OVF is unaffected by a load.
- Count: when CEP & CET & !LD.
  - Up: Q <= Q+1 if Q != MODULUS-1. At MODULUS-1: Q <= 0 if SATURATE=0, else Q holds.
  - Down: Q <= Q-1 if Q != 0. At 0: Q <= MODULUS-1 if SATURATE=0, else Q holds.
  - Arithmetic is performed in WIDTH+1 bits, so MODULUS=2**WIDTH wraps correctly.
- C:
  - C <= 1 for exactly one cycle following any counting edge taken while Q==T, in wrap or saturate mode.
  - Otherwise C <= 0.
  - In saturate mode with enables held at T, C stays high every cycle. This is an intended "pinned" indication.
- OVF:
  - Set on the same edge that C is set.
  - Cleared by MR or OVF_CLR.
  - Set wins over OVF_CLR on the same edge.
- Direction change: UP may change any cycle and takes effect on the next edge. TC reflects the new direction combinationally.
- Hold: when no enable and no load, Q, C and OVF are unchanged, except that C returns to 0.
- Reset mid-count: Q=0, C=0 and OVF=0 on the next edge regardless of LD, CEP, CET or OVF_CLR.
- Default build (WIDTH=4, MODULUS=12, SATURATE=0, CEP=CET=UP=1, LD=0) must reproduce the legacy mod-12 sequence 0..11,0 cycle for cycle.

Test Plan:
- Default params, MR for 1 cycle, then CEP=CET=UP=1 for 14 cycles:
  - Q=0,1..11,0,1.
  - TC high only while Q=11.
  - C high the cycle after the 11->0 edge.
  - OVF=1 from then on.
- UP=0 from Q=0, enables high:
  - Q=11,10,... on successive edges.
  - TC=1 at Q=0 before the first edge.
  - C pulses once after the 0->11 edge.
- LD=1 with D=9, then D=14, with CEP=1:
  - Q=9, then Q=11 (clamped).
  - No increment on load cycles.
  - C=0 on those cycles.
- SATURATE=1, up from Q=10 for 4 cycles:
  - Q=11,11,11,11.
  - C=1 from the second edge on.
  - OVF=1.
  - OVF_CLR with enables low clears OVF to 0.
- Cascade two instances (stage1.CET = stage0.TC), both MODULUS=12, count 144 cycles:
  - Stage1 increments only when stage0=11.
  - Both return to 0 at cycle 144.
  - Stage1.TC high exactly once, at count 143.
- Assert MR together with LD=1, D=5 mid-count at Q=7:
  - Q=0, C=0, OVF=0 next edge.
  - OVF_CLR and OVF set on the same edge: OVF=1.
